seq_event_reporter: RTL

Downstream consumer of the sequence detector's one-cycle match flag `z`. Each sampled match becomes a record: a timestamp, or the gap since the previous match in gap mode. Records are buffered in a small FIFO and drained over a valid/ready handshake. The block also keeps a saturating match count and a sticky overflow flag for status readout.

---
 rtl/seq_event_reporter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seq_event_reporter.sv
`default_nettype none
// ============================================================================
// Module   : seq_event_reporter
// Brief    : Turns each sampled detector match (z) into a record, which is
//            an absolute timestamp, or the gap since the previous match when
//            SEQ_EVT_GAP_EN is defined. Records are buffered in a small FIFO
//            and drained over valid/ready. The block also keeps a saturating
//            match count and a sticky overflow flag.
// Options  : `define SEQ_EVT_GAP_EN selects gap mode. The default build uses
//            absolute timestamps.
// Revision : 1.0 - initial release
// ============================================================================
module seq_event_reporter #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     z,
  input  logic                     clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_data,
  output logic [$clog2(DEPTH):0]   evt_level,
  output logic [CNT_W-1:0]         evt_count,
  output logic                     ovf
);

  localparam int               AW         = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // Free-running timestamp
  logic [TS_W-1:0]  ts_q, ts_d;

  // FIFO pointers are one bit wider than the index so that full and empty
  // can be told apart.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];

  // Status
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Handshake and datapath helpers
  logic [AW:0]      level;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [TS_W-1:0]  rec_val;

  // Occupancy, full and valid all come from the registered pointers, so
  // they change only at the edge that moves a pointer.
  always_comb begin
    level     = wptr_q - rptr_q;
    full      = (level == FULL_LEVEL);
    evt_valid = (level != '0);
    evt_data  = mem_q[rptr_q[AW-1:0]];
  end

  // Clear wins over both the event and the consumer at the same edge.
  // A full FIFO still accepts a push when the head leaves at the same edge.
  always_comb begin
    pop  = evt_valid & evt_ready & ~clr;
    push = z & ~clr & (~full | pop);
    drop = z & ~clr & full & ~pop;
  end

`ifdef SEQ_EVT_GAP_EN
  localparam logic [TS_W-1:0] GAP_MAX = '1;

  logic [TS_W-1:0] gap_q, gap_d;

  // Gap counter: saturates, and reloads to 1 on every event, including a
  // dropped one, so that the next record measures from this event.
  always_comb begin
    gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
    if (z) begin
      gap_d = TS_W'(1);
    end
    if (clr) begin
      gap_d = '0;
    end
    rec_val = gap_q;
  end

  // Gap counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  // Absolute mode: the record is the timestamp held before the capturing edge.
  always_comb begin
    rec_val = ts_q;
  end
`endif

  // Next-state logic for the timestamp, FIFO and status.
  always_comb begin
    ts_d   = ts_q + 1'b1;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (push) begin
      mem_d[wptr_q[AW-1:0]] = rec_val;
      wptr_d                = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    // Every event is counted, including one whose record is dropped.
    if (z && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end

    // Storage is left alone on clear. With the pointers at zero, its
    // contents are never presented as valid.
    if (clr) begin
      ts_d   = '0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  // State registers. Storage is reset as well, so that evt_data reads 0
  // out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ts_q   <= ts_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Status outputs
  always_comb begin
    evt_level = level;
    evt_count = cnt_q;
    ovf       = ovf_q;
  end

endmodule
`default_nettype wire
